// File: rtl/store_buffer.sv
// Store buffer between the data cache write-through path and data_mem.
// Cache writes are queued in a small FIFO and drained one per cycle over the
// single data_mem port, which is shared with cache refill reads. A refill read
// that hits a queued (or same-cycle) write is held until that write has drained.
module store_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_AW     = 17,
  parameter int DEPTH      = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_addr,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic [3:0]            push_be,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_addr,
  input  logic                  flush_req,
  output logic                  full,
  output logic                  empty,
  output logic                  rd_stall,
  output logic                  flush_done,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wd,
  output logic [3:0]            mem_we
);

  localparam int PW = $clog2(DEPTH);
  localparam int WW = DATA_WIDTH - 2;  // word-address width

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_PEND  = 2'b01;
  localparam logic [1:0] ST_FLUSH = 2'b10;

  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW:0]   CNT_MAX = (PW+1)'(DEPTH);

  // Entry storage: every entry is compared against the read address each
  // cycle, so it has to live in flops rather than a RAM.
  logic [WW-1:0]         r_addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_data_mem [DEPTH];
  logic [3:0]            r_be_mem   [DEPTH];

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic [1:0]    r_state;

  logic [PW:0]   w_count_next;
  logic [1:0]    w_state_next;
  logic [DEPTH-1:0] w_match;
  logic          w_full;
  logic          w_empty;
  logic          w_push_ok;
  logic          w_conflict;
  logic          w_serve_rd;
  logic          w_drain;
  logic [MEM_AW-1:0] w_head_addr;
  logic          w_unused;

  assign w_full    = (r_count == CNT_MAX);
  assign w_empty   = (r_count == '0);
  assign w_push_ok = push & ~w_full;

  // An entry is live when its distance from the read pointer (modulo DEPTH)
  // is below the occupancy; only live entries may cause a read conflict.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      logic [PW-1:0] w_offset;
      logic          w_valid;
      assign w_offset    = PW'(gi) - r_rd_ptr;
      assign w_valid     = ({1'b0, w_offset} < r_count);
      assign w_match[gi] = w_valid & (r_addr_mem[gi] == rd_addr[DATA_WIDTH-1:2]);
    end
  endgenerate

  // A write arriving in the same cycle as the read already counts as pending.
  assign w_conflict = (|w_match) |
                      (push & (push_addr[DATA_WIDTH-1:2] == rd_addr[DATA_WIDTH-1:2]));

  // Reads win the port unless they conflict or a flush is in progress.
  assign w_serve_rd = rd_en & ~w_conflict & (r_state != ST_FLUSH);
  assign w_drain    = ~w_serve_rd & ~w_empty;

  assign w_head_addr = MEM_AW'({r_addr_mem[r_rd_ptr], 2'b00});
  assign w_unused    = ^push_addr[1:0];

  // Drive the shared data_mem port from the arbitration result.
  always_comb begin
    mem_addr = '0;
    mem_wd   = r_data_mem[r_rd_ptr];
    mem_we   = 4'b0000;
    if (w_serve_rd) begin
      mem_addr = rd_addr[MEM_AW-1:0];
    end else if (w_drain) begin
      mem_addr = w_head_addr;
      mem_we   = RST ? 4'b0000 : r_be_mem[r_rd_ptr];
    end
  end

  assign full       = w_full;
  assign empty      = w_empty;
  assign rd_stall   = rd_en & ~w_serve_rd & ~RST;
  assign flush_done = ~RST & (r_state == ST_FLUSH) & w_empty & ~w_push_ok;

  // Occupancy: push and drain in the same cycle leave it unchanged.
  always_comb begin
    w_count_next = r_count;
    case ({w_push_ok, w_drain})
      2'b10:   w_count_next = r_count + CNT_ONE;
      2'b01:   w_count_next = r_count - CNT_ONE;
      default: w_count_next = r_count;
    endcase
  end

  // Buffer state: flush_req is only looked at outside FLUSH.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (flush_req)      w_state_next = ST_FLUSH;
        else if (w_push_ok) w_state_next = ST_PEND;
      end
      ST_PEND: begin
        if (flush_req)                w_state_next = ST_FLUSH;
        else if (w_count_next == '0)  w_state_next = ST_IDLE;
      end
      ST_FLUSH: begin
        if (w_empty & ~w_push_ok) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Write accepted entries into the slot at the write pointer.
  always_ff @(posedge CLK) begin
    if (w_push_ok) begin
      r_addr_mem[r_wr_ptr] <= push_addr[DATA_WIDTH-1:2];
      r_data_mem[r_wr_ptr] <= push_data;
      r_be_mem[r_wr_ptr]   <= push_be;
    end
  end

  // Pointers, occupancy and state; reset drops every pending entry.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_state  <= ST_IDLE;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_drain)   r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_count <= w_count_next;
      r_state <= w_state_next;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: a hand-computed cycle table, directed fill and flush
// sequences, then random traffic against a queue-based reference model.
module tb_store_buffer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        push;
  logic [31:0] push_addr;
  logic [31:0] push_data;
  logic [3:0]  push_be;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic        flush_req;
  logic        full;
  logic        empty;
  logic        rd_stall;
  logic        flush_done;
  logic [16:0] mem_addr;
  logic [31:0] mem_wd;
  logic [3:0]  mem_we;

  always #5 CLK = ~CLK;

  store_buffer #(.DATA_WIDTH(32), .MEM_AW(17), .DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .push(push), .push_addr(push_addr),
    .push_data(push_data), .push_be(push_be), .rd_en(rd_en),
    .rd_addr(rd_addr), .flush_req(flush_req), .full(full), .empty(empty),
    .rd_stall(rd_stall), .flush_done(flush_done), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_we(mem_we)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One table row = one clock cycle: inputs, then outputs expected mid-cycle.
  typedef struct {
    logic        rst;
    logic        push;
    logic [31:0] paddr;
    logic [31:0] pdata;
    logic [3:0]  pbe;
    logic        rd_en;
    logic [31:0] raddr;
    logic        flush;
    logic        e_empty;
    logic        e_full;
    logic        e_stall;
    logic [3:0]  e_we;
    logic        chk_addr;
    logic [16:0] e_addr;
    logic        chk_wd;
    logic [31:0] e_wd;
    logic        e_fdone;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input vec_t v);
    tbl.push_back(v);
  endtask

  // Reference model: pending writes as a FIFO of words, plus a flushing flag.
  logic [29:0] q_word[$];
  logic [31:0] q_data[$];
  logic [3:0]  q_be[$];
  bit          m_flush = 1'b0;
  int          fd_cnt  = 0;

  task automatic mstep(input string tag);
    bit          conflict;
    bit          serve;
    bit          acc;
    bit          done;
    logic [31:0] tmp;
    @(negedge CLK);
    conflict = 1'b0;
    foreach (q_word[i]) if (q_word[i] == rd_addr[31:2]) conflict = 1'b1;
    if (push && push_addr[31:2] == rd_addr[31:2]) conflict = 1'b1;
    serve = rd_en && !conflict && !m_flush;
    acc   = push && (q_word.size() < 4);
    done  = m_flush && (q_word.size() == 0) && !acc;
    if (flush_done) fd_cnt++;
    chk({tag, " empty"}, 32'(empty), 32'(q_word.size() == 0));
    chk({tag, " full"},  32'(full),  32'(q_word.size() == 4));
    if (RST) begin
      chk({tag, " rst we"},    32'(mem_we),     32'h0);
      chk({tag, " rst stall"}, 32'(rd_stall),   32'h0);
      chk({tag, " rst fdone"}, 32'(flush_done), 32'h0);
      q_word.delete(); q_data.delete(); q_be.delete();
      m_flush = 1'b0;
    end else begin
      chk({tag, " fdone"}, 32'(flush_done), 32'(done));
      if (serve) begin
        chk({tag, " rd addr"},  32'(mem_addr), 32'(rd_addr[16:0]));
        chk({tag, " rd we"},    32'(mem_we),   32'h0);
        chk({tag, " rd stall"}, 32'(rd_stall), 32'h0);
      end else if (q_word.size() > 0) begin
        tmp = {q_word[0], 2'b00};
        chk({tag, " dr addr"},  32'(mem_addr), 32'(tmp[16:0]));
        chk({tag, " dr wd"},    mem_wd,        q_data[0]);
        chk({tag, " dr we"},    32'(mem_we),   32'(q_be[0]));
        chk({tag, " dr stall"}, 32'(rd_stall), 32'(rd_en));
      end else begin
        chk({tag, " idle we"},    32'(mem_we),   32'h0);
        chk({tag, " idle stall"}, 32'(rd_stall), 32'(rd_en));
        if (!rd_en) chk({tag, " idle addr"}, 32'(mem_addr), 32'h0);
      end
      if (!serve && q_word.size() > 0) begin
        void'(q_word.pop_front()); void'(q_data.pop_front()); void'(q_be.pop_front());
      end
      if (acc) begin
        q_word.push_back(push_addr[31:2]);
        q_data.push_back(push_data);
        q_be.push_back(push_be);
      end
      if (m_flush) begin
        if (done) m_flush = 1'b0;
      end else if (flush_req) begin
        m_flush = 1'b1;
      end
    end
    @(posedge CLK); #1;
  endtask

  task automatic set_in(input logic p, input logic [31:0] pa, input logic [31:0] pd,
                        input logic [3:0] pb, input logic r, input logic [31:0] ra,
                        input logic f);
    push = p; push_addr = pa; push_data = pd; push_be = pb;
    rd_en = r; rd_addr = ra; flush_req = f;
  endtask

  initial begin
    RST = 1'b1;
    set_in(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);

    //  rst   push  paddr     pdata          pbe   rd    raddr     fl    emp   full  stl   we    ca    addr       cw    wd             fd
    add('{1'b1, 1'b0, 32'h000, 32'h0,        4'h0, 1'b1, 32'h040, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 17'h0,    1'b0, 32'h0,        1'b0});
    add('{1'b0, 1'b1, 32'h010, 32'h1,        4'hF, 1'b0, 32'h000, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 17'h0,    1'b0, 32'h0,        1'b0});
    add('{1'b0, 1'b1, 32'h014, 32'h2,        4'hF, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 1'b1, 17'h010,  1'b1, 32'h1,        1'b0});
    add('{1'b1, 1'b0, 32'h000, 32'h0,        4'h0, 1'b1, 32'h014, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 17'h0,    1'b0, 32'h0,        1'b0});
    add('{1'b0, 1'b0, 32'h000, 32'h0,        4'h0, 1'b0, 32'h000, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 17'h0,    1'b0, 32'h0,        1'b0});
    add('{1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0, 32'h000, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 17'h0,    1'b0, 32'h0,        1'b0});
    add('{1'b0, 1'b0, 32'h000, 32'h0,        4'h0, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 1'b1, 17'h100,  1'b1, 32'hDEADBEEF, 1'b0});
    add('{1'b0, 1'b0, 32'h000, 32'h0,        4'h0, 1'b0, 32'h000, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 17'h0,    1'b0, 32'h0,        1'b0});
    add('{1'b0, 1'b1, 32'h200, 32'h11112222, 4'h3, 1'b0, 32'h000, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 17'h0,    1'b0, 32'h0,        1'b0});
    add('{1'b0, 1'b0, 32'h000, 32'h0,        4'h0, 1'b1, 32'h202, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 1'b1, 17'h200,  1'b1, 32'h11112222, 1'b0});
    add('{1'b0, 1'b0, 32'h000, 32'h0,        4'h0, 1'b1, 32'h202, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 17'h202,  1'b0, 32'h0,        1'b0});
    add('{1'b0, 1'b1, 32'h304, 32'hA,        4'hF, 1'b0, 32'h000, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 17'h0,    1'b0, 32'h0,        1'b0});
    add('{1'b0, 1'b1, 32'h308, 32'hB,        4'hF, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 17'h300,  1'b0, 32'h0,        1'b0});
    add('{1'b0, 1'b0, 32'h000, 32'h0,        4'h0, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 17'h300,  1'b0, 32'h0,        1'b0});
    add('{1'b0, 1'b0, 32'h000, 32'h0,        4'h0, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 17'h300,  1'b0, 32'h0,        1'b0});
    add('{1'b0, 1'b0, 32'h000, 32'h0,        4'h0, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 1'b1, 17'h304,  1'b1, 32'hA,        1'b0});
    add('{1'b0, 1'b0, 32'h000, 32'h0,        4'h0, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 1'b1, 17'h308,  1'b1, 32'hB,        1'b0});
    add('{1'b0, 1'b0, 32'h000, 32'h0,        4'h0, 1'b0, 32'h000, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 17'h0,    1'b0, 32'h0,        1'b0});
    add('{1'b0, 1'b0, 32'h000, 32'h0,        4'h0, 1'b0, 32'h000, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 17'h0,    1'b0, 32'h0,        1'b0});
    add('{1'b0, 1'b0, 32'h000, 32'h0,        4'h0, 1'b0, 32'h000, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 17'h0,    1'b0, 32'h0,        1'b1});
    add('{1'b0, 1'b0, 32'h000, 32'h0,        4'h0, 1'b0, 32'h000, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 17'h0,    1'b0, 32'h0,        1'b0});
    add('{1'b0, 1'b1, 32'h400, 32'h5,        4'h0, 1'b0, 32'h000, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 17'h0,    1'b0, 32'h0,        1'b0});
    add('{1'b0, 1'b0, 32'h000, 32'h0,        4'h0, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 17'h400,  1'b1, 32'h5,        1'b0});
    add('{1'b0, 1'b0, 32'h000, 32'h0,        4'h0, 1'b0, 32'h000, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 17'h0,    1'b0, 32'h0,        1'b0});

    repeat (2) @(posedge CLK);
    #1;

    // Table phase.
    for (int i = 0; i < tbl.size(); i++) begin
      RST = tbl[i].rst;
      set_in(tbl[i].push, tbl[i].paddr, tbl[i].pdata, tbl[i].pbe,
             tbl[i].rd_en, tbl[i].raddr, tbl[i].flush);
      @(negedge CLK);
      chk($sformatf("row%0d empty", i), 32'(empty),      32'(tbl[i].e_empty));
      chk($sformatf("row%0d full", i),  32'(full),       32'(tbl[i].e_full));
      chk($sformatf("row%0d stall", i), 32'(rd_stall),   32'(tbl[i].e_stall));
      chk($sformatf("row%0d we", i),    32'(mem_we),     32'(tbl[i].e_we));
      chk($sformatf("row%0d fdone", i), 32'(flush_done), 32'(tbl[i].e_fdone));
      if (tbl[i].chk_addr) chk($sformatf("row%0d addr", i), 32'(mem_addr), 32'(tbl[i].e_addr));
      if (tbl[i].chk_wd)   chk($sformatf("row%0d wd", i),   mem_wd,        tbl[i].e_wd);
      $display("[TB] row %0d: we=%h addr=%h stall=%b empty=%b", i, mem_we, mem_addr, rd_stall, empty);
      @(posedge CLK); #1;
    end

    // Model phase starts from a clean reset so model and DUT agree.
    RST = 1'b1;
    set_in(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
    mstep("sync rst");
    RST = 1'b0;

    // Fill with a non-matching read held, overfill, then drain in order.
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, 32'h500 + 32'(4 * k), 32'hC0DE0000 + 32'(k), 4'hF, 1'b1, 32'h800, 1'b0);
      mstep($sformatf("fill push%0d", k));
    end
    set_in(1'b1, 32'h510, 32'hBAD0, 4'hF, 1'b1, 32'h800, 1'b0);
    mstep("fill push-full");
    set_in(1'b1, 32'h514, 32'hBAD1, 4'hF, 1'b0, 32'h0, 1'b0);
    mstep("fill push-full-drain");
    set_in(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 4; k++) mstep($sformatf("fill drain%0d", k));
    $display("[TB] fill sequence done, empty=%b", empty);

    // Flush with reads pending and a push during FLUSH.
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, 32'h600 + 32'(4 * k), 32'hF0000000 + 32'(k), 4'hF, 1'b1, 32'h900, 1'b0);
      mstep($sformatf("flush pre%0d", k));
    end
    set_in(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h900, 1'b1);
    mstep("flush req");
    fd_cnt = 0;
    set_in(1'b1, 32'h60C, 32'hF0000003, 4'hF, 1'b1, 32'h900, 1'b0);
    mstep("flush push");
    set_in(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h900, 1'b0);
    for (int k = 0; k < 6; k++) mstep($sformatf("flush cyc%0d", k));
    chk("flush pulses", 32'(fd_cnt), 32'd1);
    $display("[TB] flush sequence done, flush_done pulses=%0d", fd_cnt);

    // Random traffic on a small address window to provoke conflicts.
    for (int n = 0; n < 3000; n++) begin
      RST = ($urandom_range(0, 99) == 0);
      set_in(($urandom_range(0, 9) < 6),
             32'h1000 + 32'($urandom_range(0, 31)),
             $urandom(),
             4'($urandom_range(0, 15)),
             ($urandom_range(0, 1) == 1),
             32'h1000 + 32'($urandom_range(0, 35)),
             ($urandom_range(0, 19) == 0));
      mstep($sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
